cordic_sincos_postprocess: RTL and testbench

Final stage of the CORDIC sin/cos pipeline. It takes the rotated cos/sin pair from the last CORDIC iteration stage and applies the quadrant sign correction produced by preprocessing, saturating where needed. Results are buffered in a small FIFO and handed to the UART transmit side over a ready/valid handshake. It also generates the pipeline-wide enable, so that downstream backpressure stalls the preprocess and iteration stages without losing results.

---
 rtl/cordic_sincos_postprocess_pkg.sv | 28 ++
 rtl/cordic_sincos_out_fifo.sv | 57 +++++
 rtl/cordic_sincos_postprocess.sv | 73 +++++++
 tb/tb_cordic_sincos_postprocess.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_sincos_postprocess_pkg.sv
// rtl/cordic_sincos_postprocess_pkg.sv - shared types and saturating negation for the CORDIC sin/cos pipeline
package pkg_cordic_sincos;

  localparam int RESULT_BITS = 16;
  localparam int SAT_MAX_BITS = 64;

  typedef struct packed {
    logic signed [RESULT_BITS-1:0] cos;
    logic signed [RESULT_BITS-1:0] sin;
  } cordic_result_t;

  // value holds a bits-wide two's complement number in its low bits; the most
  // negative code has no positive twin, so it clamps to the largest positive code
  function automatic logic [SAT_MAX_BITS-1:0] sat_neg(input logic [SAT_MAX_BITS-1:0] value,
                                                      input int bits);
    logic [SAT_MAX_BITS-1:0] mask;
    logic [SAT_MAX_BITS-1:0] min_val;
    logic [SAT_MAX_BITS-1:0] neg;
    mask    = (bits >= SAT_MAX_BITS) ? '1 : ((64'd1 << bits) - 64'd1);
    min_val = 64'd1 << (bits - 1);
    neg     = (~value + 64'd1) & mask;
    if ((value & mask) == min_val) begin
      return min_val - 64'd1;
    end
    return neg;
  endfunction

endpackage

// File: rtl/cordic_sincos_out_fifo.sv
// rtl/cordic_sincos_out_fifo.sv - first-word fall-through output FIFO with look-ahead count
module cordic_sincos_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       ready,
  output logic                       valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop;

  assign valid      = (count != '0);
  assign rd_data    = mem[rd_ptr];
  assign pop        = valid & ready;
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

  // the enable register upstream must keep a free slot whenever it lets a push through
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count == FULL)));
    end
  end

endmodule

// File: rtl/cordic_sincos_postprocess.sv
// rtl/cordic_sincos_postprocess.sv - quadrant sign correction, output buffering and pipeline enable
module cordic_sincos_postprocess
  import pkg_cordic_sincos::*;
#(
  parameter int BITS  = 16,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_sign,
  input  logic [BITS-1:0] i_cos,
  input  logic [BITS-1:0] i_sin,
  output logic            o_pipeline_en,
  output logic            o_valid,
  output logic [BITS-1:0] o_cos,
  output logic [BITS-1:0] o_sin,
  input  logic            i_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [BITS-1:0] cos_corr;
  logic [BITS-1:0] sin_corr;
  logic            s1_valid;
  logic [BITS-1:0] s1_cos;
  logic [BITS-1:0] s1_sin;
  logic            push;
  logic [CW-1:0]   count_next;

  always_comb begin
    cos_corr = i_cos;
    sin_corr = i_sin;
    if (i_sign) begin
      cos_corr = BITS'(sat_neg(64'(i_cos), BITS));
      sin_corr = BITS'(sat_neg(64'(i_sin), BITS));
    end
  end

  assign push = o_pipeline_en & s1_valid;

  // en looks one cycle ahead so a push is never presented to a full FIFO
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid      <= 1'b0;
      s1_cos        <= '0;
      s1_sin        <= '0;
      o_pipeline_en <= 1'b1;
    end else begin
      if (o_pipeline_en) begin
        s1_valid <= i_valid;
        s1_cos   <= cos_corr;
        s1_sin   <= sin_corr;
      end
      o_pipeline_en <= (count_next < CW'(DEPTH));
    end
  end

  cordic_sincos_out_fifo #(
    .WIDTH (2 * BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (i_clk),
    .rst        (i_rst),
    .push       (push),
    .wr_data    ({s1_cos, s1_sin}),
    .ready      (i_ready),
    .valid      (o_valid),
    .rd_data    ({o_cos, o_sin}),
    .count_next (count_next)
  );

endmodule

// File: tb/tb_cordic_sincos_postprocess.sv
// tb/tb_cordic_sincos_postprocess.sv - self-checking bench for cordic_sincos_postprocess
module tb_cordic_sincos_postprocess;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_sign = 1'b0;
  logic [15:0] i_cos = '0;
  logic [15:0] i_sin = '0;
  logic        i_ready = 1'b0;
  logic        o_pipeline_en;
  logic        o_valid;
  logic [15:0] o_cos;
  logic [15:0] o_sin;

  int n_total = 0;
  int n_pass = 0;
  int n_popped = 0;
  logic sender_done = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cordic_sincos_postprocess #(.BITS(16), .DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (i_valid),
    .i_sign        (i_sign),
    .i_cos         (i_cos),
    .i_sin         (i_sin),
    .o_pipeline_en (o_pipeline_en),
    .o_valid       (o_valid),
    .o_cos         (o_cos),
    .o_sin         (o_sin),
    .i_ready       (i_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] corr(input logic s, input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (!s) return x;
    if (v == -32768) return 16'h7FFF;
    v = -v;
    return v[15:0];
  endfunction

  // Reference: every consumed input is queued, and must emerge corrected, in order, once.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (o_valid) begin
        chk("head_present", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          chk("head_data", {o_cos, o_sin}, exp_q[0]);
          if (i_ready) begin
            void'(exp_q.pop_front());
            n_popped++;
          end
        end
      end
      if (o_pipeline_en && i_valid)
        exp_q.push_back({corr(i_sign, i_cos), corr(i_sign, i_sin)});
    end
  end

  task automatic send(input logic s, input logic [15:0] c, input logic [15:0] sn);
    int n = 0;
    i_valid = 1'b1; i_sign = s; i_cos = c; i_sin = sn;
    @(negedge clk);
    while (!o_pipeline_en) begin
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic stream(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) send(k[0], 16'(base + 16'(k)), ~16'(base + 16'(k)));
    sender_done = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sender;
    int n = 0;
    while (!sender_done && n < 200) begin
      cyc(1);
      n++;
    end
    chk("sender_done", {31'd0, sender_done}, 32'd1);
  endtask

  // Called right after an edge with the FIFO empty; result must show two cycles later.
  task automatic lat_check(input string tag, input logic s, input logic [15:0] c,
                           input logic [15:0] sn, input logic [15:0] ec, input logic [15:0] es);
    i_ready = 1'b1; i_valid = 1'b1; i_sign = s; i_cos = c; i_sin = sn;
    cyc(1);
    i_valid = 1'b0; i_sign = 1'b0;
    chk({tag, "_c1_valid"}, {31'd0, o_valid}, 32'd0);
    cyc(1);
    chk({tag, "_c2_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_c2_cos"}, {16'd0, o_cos}, {16'd0, ec});
    chk({tag, "_c2_sin"}, {16'd0, o_sin}, {16'd0, es});
    cyc(1);
    chk({tag, "_c3_valid"}, {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk("rst_en", {31'd0, o_pipeline_en}, 32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_cos", {16'd0, o_cos}, 32'd0);
    chk("rst_sin", {16'd0, o_sin}, 32'd0);

    lat_check("lat", 1'b0, 16'h2000, 16'h1000, 16'h2000, 16'h1000);
    lat_check("neg", 1'b1, 16'h4000, 16'h8000, 16'hC000, 16'h7FFF);
    lat_check("neg0", 1'b1, 16'h0000, 16'h7FFF, 16'h0000, 16'h8001);

    // backpressure: six results against a stalled consumer
    i_ready = 1'b0; sender_done = 1'b0; p0 = n_popped;
    fork stream(6, 16'h1000); join_none
    cyc(4);
    chk("bp_en_c4", {31'd0, o_pipeline_en}, 32'd1);
    cyc(1);
    chk("bp_en_c5", {31'd0, o_pipeline_en}, 32'd0);
    cyc(3);
    chk("bp_en_c8", {31'd0, o_pipeline_en}, 32'd0);
    chk("bp_head_cos", {16'd0, o_cos}, 32'h0000_1000);
    chk("bp_head_sin", {16'd0, o_sin}, 32'h0000_EFFF);
    i_ready = 1'b1;
    wait_sender();
    cyc(10);
    chk("bp_popped", n_popped - p0, 32'd6);
    chk("bp_q_empty", exp_q.size(), 32'd0);

    // push and pop together at count 3, then a bare pop from full
    i_ready = 1'b0; sender_done = 1'b0; p0 = n_popped;
    fork stream(5, 16'h2000); join_none
    cyc(4);
    i_ready = 1'b1;
    chk("pp_en_c4", {31'd0, o_pipeline_en}, 32'd1);
    cyc(1);
    i_ready = 1'b0;
    chk("pp_en_c5", {31'd0, o_pipeline_en}, 32'd1);
    cyc(1);
    chk("pp_en_c6", {31'd0, o_pipeline_en}, 32'd0);
    i_ready = 1'b1;
    cyc(1);
    chk("pp_en_c7", {31'd0, o_pipeline_en}, 32'd1);
    wait_sender();
    cyc(8);
    chk("pp_popped", n_popped - p0, 32'd5);
    chk("pp_q_empty", exp_q.size(), 32'd0);

    // reset with three stored entries and a valid result in the stage register
    i_ready = 1'b0; sender_done = 1'b0;
    fork stream(4, 16'h3000); join_none
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mrst_valid", {31'd0, o_valid}, 32'd0);
    chk("mrst_en", {31'd0, o_pipeline_en}, 32'd1);
    lat_check("post_rst", 1'b0, 16'h0123, 16'hFEDC, 16'h0123, 16'hFEDC);

    // idle with the consumer ready
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("idle_valid", {31'd0, o_valid}, 32'd0);
      chk("idle_en", {31'd0, o_pipeline_en}, 32'd1);
    end
    chk("idle_q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
